// File: rtl/if_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch controller
// (master) and the instruction memory (slave).
interface if_fetch_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_data_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_ack_i,
      input  imem_data_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_ack_i,
      output imem_data_i
   );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch controller: captures the PC, runs a variable-latency
// req/ack fetch, holds the PC until the fetch resolves, and loads IF/ID
// while honouring the ID-stage stall and the branch flush.
module if_fetch #(
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] pc_i,
   output logic        pc_stall_o,
   input  logic        stall_i,
   input  logic        flush_i,
   if_fetch_if.master  imem,
   output logic [31:0] ifid_inst_o,
   output logic [31:0] ifid_pc_o,
   output logic        ifid_valid_o
);

   typedef enum logic [1:0] {
      ST_ISSUE = 2'd0,
      ST_REQ   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_fetch_addr;
   logic [31:0] r_buf;
   logic [31:0] r_ifid_inst;
   logic [31:0] r_ifid_pc;
   logic        r_ifid_valid;

   logic        w_pc_stall;
   logic        w_deliver;
   logic [31:0] w_deliver_inst;
   logic        w_capture_pc;
   logic        w_capture_buf;
   logic [31:0] w_next_pc;

   // PC+4 of the instruction being delivered; wraps modulo 2^32
   assign w_next_pc = r_fetch_addr + 32'd4;

   // Next-state, PC-stall and delivery decode; flush beats ack and stall
   always_comb begin
      w_state_next   = r_state;
      w_pc_stall     = 1'b1;
      w_deliver      = 1'b0;
      w_deliver_inst = imem.imem_data_i;
      w_capture_pc   = 1'b0;
      w_capture_buf  = 1'b0;
      unique case (r_state)
         ST_ISSUE: begin
            if (flush_i) begin
               // Let the PC load the branch target before issuing
               w_pc_stall = 1'b0;
            end else if (start_i) begin
               w_capture_pc = 1'b1;
               w_state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            if (flush_i) begin
               w_pc_stall   = 1'b0;
               // An unacked request must still be drained to keep the bus sane
               w_state_next = imem.imem_ack_i ? ST_ISSUE : ST_DRAIN;
            end else if (imem.imem_ack_i) begin
               if (!stall_i) begin
                  w_deliver    = 1'b1;
                  w_pc_stall   = 1'b0;
                  w_state_next = ST_ISSUE;
               end else begin
                  w_capture_buf = 1'b1;
                  w_state_next  = ST_HOLD;
               end
            end
         end
         ST_DRAIN: begin
            // A further flush here must still redirect the PC
            w_pc_stall = ~flush_i;
            if (imem.imem_ack_i) begin
               w_state_next = ST_ISSUE;
            end
         end
         ST_HOLD: begin
            w_deliver_inst = r_buf;
            if (flush_i) begin
               w_pc_stall   = 1'b0;
               w_state_next = ST_ISSUE;
            end else if (!stall_i) begin
               w_deliver    = 1'b1;
               w_pc_stall   = 1'b0;
               w_state_next = ST_ISSUE;
            end
         end
         default: begin
            w_state_next = ST_ISSUE;
         end
      endcase
   end

   // State register; reset abandons any outstanding request at once
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_ISSUE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Fetch address captured from the PC when a fetch is issued
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_fetch_addr <= 32'd0;
      end else if (w_capture_pc) begin
         r_fetch_addr <= pc_i;
      end
   end

   // Buffer for a word that arrived while IF/ID was stalled
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_buf <= 32'd0;
      end else if (w_capture_buf) begin
         r_buf <= imem.imem_data_i;
      end
   end

   // IF/ID register: flush, then stall, then delivery, else bubble
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ifid_inst  <= 32'd0;
         r_ifid_pc    <= 32'd0;
         r_ifid_valid <= 1'b0;
      end else if (flush_i) begin
         r_ifid_inst  <= NOP_INST;
         r_ifid_pc    <= 32'd0;
         r_ifid_valid <= 1'b0;
      end else if (stall_i) begin
         r_ifid_inst  <= r_ifid_inst;
         r_ifid_pc    <= r_ifid_pc;
         r_ifid_valid <= r_ifid_valid;
      end else if (w_deliver) begin
         r_ifid_inst  <= w_deliver_inst;
         r_ifid_pc    <= w_next_pc;
         r_ifid_valid <= 1'b1;
      end else begin
         r_ifid_inst  <= NOP_INST;
         r_ifid_pc    <= 32'd0;
         r_ifid_valid <= 1'b0;
      end
   end

   // Reset holds the PC regardless of any flush request
   assign pc_stall_o       = rst_i | w_pc_stall;
   assign imem.imem_req_o  = (r_state == ST_REQ) || (r_state == ST_DRAIN);
   assign imem.imem_addr_o = r_fetch_addr;
   assign ifid_inst_o      = r_ifid_inst;
   assign ifid_pc_o        = r_ifid_pc;
   assign ifid_valid_o     = r_ifid_valid;

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch: zero-wait fetch, wait states, stall/HOLD,
// flush/DRAIN, flush with ack under stall, reset mid-request and PC wrap.
module tb_if_fetch;
   localparam logic [31:0] D0 = 32'h1111_0000;
   localparam logic [31:0] D4 = 32'h2222_0004;
   localparam logic [31:0] DW3 = 32'h3333_0100;
   localparam logic [31:0] DH = 32'h4444_0200;
   localparam logic [31:0] DX = 32'hDEAD_BEEF;
   localparam logic [31:0] DY = 32'h5555_0400;
   localparam logic [31:0] DZ = 32'h6666_0500;
   localparam logic [31:0] DWR = 32'h7777_FFFC;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] pc;
   logic        pc_stall;
   logic        stall;
   logic        flush;
   logic [31:0] ifid_inst;
   logic [31:0] ifid_pc;
   logic        ifid_valid;

   int n_checks = 0;
   int n_fail = 0;

   if_fetch_if imem_bus ();

   if_fetch #(.NOP_INST(32'h0000_0000)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .pc_i         (pc),
      .pc_stall_o   (pc_stall),
      .stall_i      (stall),
      .flush_i      (flush),
      .imem         (imem_bus),
      .ifid_inst_o  (ifid_inst),
      .ifid_pc_o    (ifid_pc),
      .ifid_valid_o (ifid_valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; pc = 32'd0; stall = 1'b0; flush = 1'b1;
      imem_bus.imem_ack_i = 1'b0; imem_bus.imem_data_i = 32'd0;
      #1;
      n_checks++;
      if (pc_stall !== 1'b1) begin n_fail++; $display("FAIL reset_pc_stall: got %b expected 1", pc_stall); end
      n_checks++;
      if (imem_bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_bus.imem_req_o); end
      n_checks++;
      if ({ifid_inst, ifid_pc, ifid_valid} !== 65'd0) begin n_fail++; $display("FAIL reset_ifid: got %h %h %b expected 0 0 0", ifid_inst, ifid_pc, ifid_valid); end
      tick();
      tick();
      rst = 1'b0; flush = 1'b0;
      $display("reset: done");
   endtask

   task automatic test_zero_wait();
      start = 1'b1; pc = 32'h0;
      #1;
      n_checks++;
      if (pc_stall !== 1'b1 || imem_bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL zw_issue: got stall=%b req=%b expected 1 0", pc_stall, imem_bus.imem_req_o); end
      tick();
      imem_bus.imem_ack_i = 1'b1; imem_bus.imem_data_i = D0;
      #1;
      n_checks++;
      if (imem_bus.imem_req_o !== 1'b1 || imem_bus.imem_addr_o !== 32'h0 || pc_stall !== 1'b0) begin n_fail++; $display("FAIL zw_req0: got req=%b addr=%h stall=%b expected 1 0 0", imem_bus.imem_req_o, imem_bus.imem_addr_o, pc_stall); end
      tick();
      imem_bus.imem_ack_i = 1'b0; pc = 32'h4;
      n_checks++;
      if (ifid_inst !== D0 || ifid_pc !== 32'h4 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL zw_ifid0: got %h %h %b expected %h 4 1", ifid_inst, ifid_pc, ifid_valid, D0); end
      #1;
      n_checks++;
      if (pc_stall !== 1'b1 || imem_bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL zw_issue2: got stall=%b req=%b expected 1 0", pc_stall, imem_bus.imem_req_o); end
      tick();
      n_checks++;
      if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL zw_bubble: got valid %b expected 0", ifid_valid); end
      imem_bus.imem_ack_i = 1'b1; imem_bus.imem_data_i = D4;
      #1;
      n_checks++;
      if (imem_bus.imem_addr_o !== 32'h4 || pc_stall !== 1'b0) begin n_fail++; $display("FAIL zw_req4: got addr=%h stall=%b expected 4 0", imem_bus.imem_addr_o, pc_stall); end
      tick();
      imem_bus.imem_ack_i = 1'b0; start = 1'b0;
      n_checks++;
      if (ifid_inst !== D4 || ifid_pc !== 32'h8 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL zw_ifid4: got %h %h %b expected %h 8 1", ifid_inst, ifid_pc, ifid_valid, D4); end
      $display("zero_wait: two fetches delivered");
   endtask

   task automatic test_wait_states();
      start = 1'b1; pc = 32'h100;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (imem_bus.imem_addr_o !== 32'h100 || imem_bus.imem_req_o !== 1'b1 || pc_stall !== 1'b1) begin n_fail++; $display("FAIL ws_wait%0d: got addr=%h req=%b stall=%b expected 100 1 1", i, imem_bus.imem_addr_o, imem_bus.imem_req_o, pc_stall); end
         tick();
         n_checks++;
         if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL ws_bubble%0d: got valid %b expected 0", i, ifid_valid); end
      end
      imem_bus.imem_ack_i = 1'b1; imem_bus.imem_data_i = DW3;
      #1;
      n_checks++;
      if (imem_bus.imem_addr_o !== 32'h100 || pc_stall !== 1'b0) begin n_fail++; $display("FAIL ws_ack: got addr=%h stall=%b expected 100 0", imem_bus.imem_addr_o, pc_stall); end
      tick();
      imem_bus.imem_ack_i = 1'b0;
      n_checks++;
      if (ifid_inst !== DW3 || ifid_pc !== 32'h104 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL ws_ifid: got %h %h %b expected %h 104 1", ifid_inst, ifid_pc, ifid_valid, DW3); end
      $display("wait_states: delivered after 3 wait cycles");
   endtask

   task automatic test_stall_hold();
      stall = 1'b1; start = 1'b1; pc = 32'h200;
      tick();
      start = 1'b0;
      imem_bus.imem_ack_i = 1'b1; imem_bus.imem_data_i = DH;
      #1;
      n_checks++;
      if (pc_stall !== 1'b1) begin n_fail++; $display("FAIL hold_ack_stall: got %b expected 1", pc_stall); end
      tick();
      imem_bus.imem_ack_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (ifid_inst !== DW3 || ifid_pc !== 32'h104 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL hold_keep%0d: got %h %h %b expected %h 104 1", i, ifid_inst, ifid_pc, ifid_valid, DW3); end
         #1;
         n_checks++;
         if (pc_stall !== 1'b1 || imem_bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL hold_state%0d: got stall=%b req=%b expected 1 0", i, pc_stall, imem_bus.imem_req_o); end
         tick();
      end
      stall = 1'b0;
      #1;
      n_checks++;
      if (pc_stall !== 1'b0) begin n_fail++; $display("FAIL hold_release_stall: got %b expected 0", pc_stall); end
      tick();
      n_checks++;
      if (ifid_inst !== DH || ifid_pc !== 32'h204 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL hold_ifid: got %h %h %b expected %h 204 1", ifid_inst, ifid_pc, ifid_valid, DH); end
      $display("stall_hold: buffered word delivered after stall");
   endtask

   task automatic test_flush_drain();
      start = 1'b1; pc = 32'h300;
      tick();
      start = 1'b0;
      tick();
      flush = 1'b1;
      #1;
      n_checks++;
      if (pc_stall !== 1'b0 || imem_bus.imem_req_o !== 1'b1) begin n_fail++; $display("FAIL fl_flush: got stall=%b req=%b expected 0 1", pc_stall, imem_bus.imem_req_o); end
      tick();
      flush = 1'b0; pc = 32'h400;
      n_checks++;
      if (ifid_inst !== 32'h0 || ifid_valid !== 1'b0) begin n_fail++; $display("FAIL fl_ifid_clear: got %h %b expected 0 0", ifid_inst, ifid_valid); end
      #1;
      n_checks++;
      if (imem_bus.imem_req_o !== 1'b1 || pc_stall !== 1'b1) begin n_fail++; $display("FAIL fl_drain: got req=%b stall=%b expected 1 1", imem_bus.imem_req_o, pc_stall); end
      tick();
      imem_bus.imem_ack_i = 1'b1; imem_bus.imem_data_i = DX;
      #1;
      n_checks++;
      if (imem_bus.imem_req_o !== 1'b1) begin n_fail++; $display("FAIL fl_drain_ack_req: got %b expected 1", imem_bus.imem_req_o); end
      tick();
      imem_bus.imem_ack_i = 1'b0;
      n_checks++;
      if (ifid_valid !== 1'b0 || ifid_inst !== 32'h0) begin n_fail++; $display("FAIL fl_dropped: got %h %b expected 0 0", ifid_inst, ifid_valid); end
      start = 1'b1;
      tick();
      start = 1'b0;
      #1;
      n_checks++;
      if (imem_bus.imem_addr_o !== 32'h400 || imem_bus.imem_req_o !== 1'b1) begin n_fail++; $display("FAIL fl_newpc: got addr=%h req=%b expected 400 1", imem_bus.imem_addr_o, imem_bus.imem_req_o); end
      imem_bus.imem_ack_i = 1'b1; imem_bus.imem_data_i = DY;
      tick();
      imem_bus.imem_ack_i = 1'b0;
      n_checks++;
      if (ifid_inst !== DY || ifid_pc !== 32'h404 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL fl_refetch: got %h %h %b expected %h 404 1", ifid_inst, ifid_pc, ifid_valid, DY); end
      $display("flush_drain: drained word dropped, refetch from 0x400");
   endtask

   task automatic test_flush_ack_stall();
      stall = 1'b1; start = 1'b1; pc = 32'h500;
      tick();
      start = 1'b0;
      flush = 1'b1; imem_bus.imem_ack_i = 1'b1; imem_bus.imem_data_i = DZ;
      #1;
      n_checks++;
      if (pc_stall !== 1'b0) begin n_fail++; $display("FAIL fa_stall: got %b expected 0", pc_stall); end
      tick();
      flush = 1'b0; imem_bus.imem_ack_i = 1'b0;
      n_checks++;
      if (ifid_inst !== 32'h0 || ifid_pc !== 32'h0 || ifid_valid !== 1'b0) begin n_fail++; $display("FAIL fa_ifid: got %h %h %b expected 0 0 0", ifid_inst, ifid_pc, ifid_valid); end
      #1;
      n_checks++;
      if (imem_bus.imem_req_o !== 1'b0 || pc_stall !== 1'b1) begin n_fail++; $display("FAIL fa_issue: got req=%b stall=%b expected 0 1", imem_bus.imem_req_o, pc_stall); end
      stall = 1'b0;
      $display("flush_ack_stall: data dropped, back in ISSUE");
   endtask

   task automatic test_wrap_and_reset();
      start = 1'b1; pc = 32'hFFFF_FFFC;
      tick();
      start = 1'b0;
      imem_bus.imem_ack_i = 1'b1; imem_bus.imem_data_i = DWR;
      tick();
      imem_bus.imem_ack_i = 1'b0;
      n_checks++;
      if (ifid_inst !== DWR || ifid_pc !== 32'h0 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_ifid: got %h %h %b expected %h 0 1", ifid_inst, ifid_pc, ifid_valid, DWR); end
      stall = 1'b1; start = 1'b1; pc = 32'h600;
      tick();
      start = 1'b0;
      #1;
      n_checks++;
      if (imem_bus.imem_req_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_req: got %b expected 1", imem_bus.imem_req_o); end
      #2;
      rst = 1'b1; flush = 1'b1;
      #1;
      n_checks++;
      if (imem_bus.imem_req_o !== 1'b0 || pc_stall !== 1'b1) begin n_fail++; $display("FAIL rst_mid_req: got req=%b stall=%b expected 0 1", imem_bus.imem_req_o, pc_stall); end
      n_checks++;
      if (imem_bus.imem_addr_o !== 32'h0 || ifid_inst !== 32'h0 || ifid_pc !== 32'h0 || ifid_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_regs: got addr=%h %h %h %b expected 0 0 0 0", imem_bus.imem_addr_o, ifid_inst, ifid_pc, ifid_valid); end
      tick();
      n_checks++;
      if (pc_stall !== 1'b1) begin n_fail++; $display("FAIL rst_hold_stall: got %b expected 1", pc_stall); end
      rst = 1'b0; flush = 1'b0; stall = 1'b0;
      $display("wrap_and_reset: wrap to 0, reset abandons request");
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_stall_hold();
      test_flush_drain();
      test_flush_ack_stall();
      test_wrap_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Safety net so the run always terminates
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch controller between the PC register and the IF/ID pipeline register. It takes the current PC and fetches the instruction from a variable-latency instruction memory over a req/ack handshake. While a fetch is incomplete it holds the PC through `pc_stall_o`. It then delivers `{instruction, PC+4, valid}` into IF/ID, honouring the ID-stage stall and the branch flush.

## Interface
- `NOP_INST`, default 32'h0000_0000: instruction word driven into IF/ID on bubbles and flushes.
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `rst_i`, input, 1: asynchronous, active-high reset.
- `start_i`, input, 1: CPU run enable. Fetches issue only while it is high.
- `pc_i`, input, 32: current PC from the PC register.
- `pc_stall_o`, output, 1: drives the PC register's stall input. 1 means hold the PC; 0 means the PC loads its next value at this edge.
- `stall_i`, input, 1: hazard-unit stall of IF/ID. When high, IF/ID holds.
- `flush_i`, input, 1: taken branch or jump. Discards the in-flight instruction and lets the PC load the target.
- `imem_req_o`, output, 1: memory request.
- `imem_addr_o`, output, 32: request address. Stable while `imem_req_o` is high.
- `imem_ack_i`, input, 1: single-cycle data-valid strobe. It is only meaningful while `imem_req_o` is high.
- `imem_data_i`, input, 32: instruction word, valid with `imem_ack_i`.
- `ifid_inst_o`, output, 32: IF/ID instruction.
- `ifid_pc_o`, output, 32: IF/ID PC+4.
- `ifid_valid_o`, output, 1: IF/ID holds a real instruction.

## Operation
- State register has four states: ISSUE, REQ, DRAIN and HOLD.
- Registered data: `fetch_addr_q` (32), `buf_q` (32).
- `imem_req_o` = (state is REQ or DRAIN).
- `imem_addr_o` = `fetch_addr_q`.
- IF/ID update rule, evaluated every edge in priority order:
  - `flush_i` high: load `{NOP_INST, 0, valid=0}`, regardless of `stall_i`.
  - else `stall_i` high: hold.
  - else an instruction is delivered this cycle: load `{inst, fetch_addr_q+4, 1}`. The addition is 32-bit modulo.
  - else: load the bubble `{NOP_INST, 0, 0}`.
- ISSUE state:
  - `flush_i` high: `pc_stall_o`=0; stay in ISSUE.
  - else `start_i` high: `fetch_addr_q` <= `pc_i`; go to REQ; `pc_stall_o`=1.
  - else: stay in ISSUE; `pc_stall_o`=1.
- REQ state:
  - `flush_i` high: `pc_stall_o`=0. If `imem_ack_i` is high, drop the data and go to ISSUE; else go to DRAIN.
  - `imem_ack_i` high and `stall_i` low: deliver `imem_data_i`; `pc_stall_o`=0; go to ISSUE.
  - `imem_ack_i` high and `stall_i` high: `buf_q` <= `imem_data_i`; `pc_stall_o`=1; go to HOLD.
  - no ack: `pc_stall_o`=1; stay in REQ.
- DRAIN state (a request is still outstanding after a flush):
  - `imem_ack_i` high: drop the data; go to ISSUE.
  - `pc_stall_o` = ~`flush_i`, so a further flush still redirects the PC.
- HOLD state:
  - `flush_i` high: drop `buf_q`; `pc_stall_o`=0; go to ISSUE.
  - else `stall_i` low: deliver `buf_q`; `pc_stall_o`=0; go to ISSUE.
  - else: `pc_stall_o`=1; stay in HOLD.
- `flush_i` always has priority over `stall_i` and over an ack in the same cycle.
- `start_i` is sampled only in ISSUE. Its deassertion never aborts an outstanding request.

## Timing
- Reset (asynchronous, on `rst_i` rising, held while high):
  - state = ISSUE.
  - `fetch_addr_q`, `buf_q`, `ifid_inst_o`, `ifid_pc_o` = 0.
  - `ifid_valid_o` = 0.
  - `imem_req_o` = 0.
  - `pc_stall_o` is forced to 1 while `rst_i` is high; `flush_i` is ignored.
- Reset mid-request abandons the request immediately: `imem_req_o` drops without waiting for an ack.
- `imem_req_o` rises the cycle after ISSUE captures `pc_i`.
- `imem_ack_i` may be high in that first REQ cycle (zero-wait memory).
- Best-case throughput is one instruction per 2 cycles: ISSUE then REQ with an immediate ack.
- Fetch-to-IF/ID latency is 1 edge after the ack cycle, or 1 edge after `stall_i` falls when in HOLD.
- `pc_stall_o` is combinational from state, `imem_ack_i`, `stall_i` and `flush_i`. It is low for exactly one cycle per delivered instruction or per flush cycle.

## Test plan
- Zero-wait memory, `start_i`=1, PC advancing 0, 4, 8:
  - IF/ID shows `(inst@0, pc 4)`, then `(inst@4, pc 8)` two cycles later.
  - `pc_stall_o` pulses low once per fetch.
- Ack after 3 wait cycles with `stall_i`=0:
  - `imem_addr_o` is stable for 4 cycles.
  - `ifid_valid_o` shows 0 bubbles until the delivery edge.
  - `ifid_pc_o` = `fetch_addr_q`+4.
- Ack while `stall_i`=1, with `stall_i` held 2 more cycles:
  - IF/ID holds its old contents.
  - HOLD is entered.
  - The buffered word appears in IF/ID on the edge after `stall_i` falls.
  - The PC is held throughout.
- `flush_i` pulsed 1 cycle into a 4-cycle-latency request:
  - `pc_stall_o`=0 that cycle.
  - IF/ID is cleared to NOP with valid 0.
  - DRAIN keeps the request high until the ack; the returned word never reaches IF/ID.
  - The next fetch uses the new `pc_i`.
- `flush_i` and `imem_ack_i` high together, with `stall_i`=1: data dropped, IF/ID cleared despite stall, next state ISSUE.
- `rst_i` asserted during REQ, and `fetch_addr_q`=0xFFFF_FFFC delivery:
  - Reset: all outputs reach their reset values immediately.
  - Delivery from 0xFFFF_FFFC gives `ifid_pc_o` = 0x0000_0000 (wrap).
